// File: rtl/dmem_arbiter_if.sv
// Bundle of the two master ports and the shared memory/IO bus around dmem_arbiter.
// The arbiter takes the slave view; masters and the decoder together take the master view.
interface dmem_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [31:0] m1_rdata;

   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        busy;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  bus_rdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output bus_we, bus_addr, bus_wdata, busy
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output bus_rdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  bus_we, bus_addr, bus_wdata, busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data-memory/IO bus: one transaction at a time,
// IDLE (grant) -> ACCESS (one bus cycle) -> RESP (rvalid pulse).
module dmem_arbiter_chk (
   input logic clk,
   input logic reset,
   input logic m0_gnt,
   input logic m1_gnt,
   input logic m0_rvalid,
   input logic m1_rvalid,
   input logic bus_we,
   input logic busy
);
   a_gnt_excl: assert property (@(posedge clk) disable iff (reset) !(m0_gnt && m1_gnt));
   a_rvalid_excl: assert property (@(posedge clk) disable iff (reset) !(m0_rvalid && m1_rvalid));
   a_we_busy: assert property (@(posedge clk) disable iff (reset) bus_we |-> busy);
   a_gnt_idle: assert property (@(posedge clk) disable iff (reset) (m0_gnt || m1_gnt) |-> !busy);
endmodule

module dmem_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input logic          clk,
   input logic          reset,
   dmem_arbiter_if.slave arb
);
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_m0_gnt;
   logic        w_m1_gnt;
   logic        w_pick_m1;
   logic        r_winner;      // 0 = m0, 1 = m1
   logic        r_last_grant;  // 0 = m0, 1 = m1
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;
   logic [31:0] r_m0_rdata;
   logic [31:0] r_m1_rdata;
   logic        r_m0_rvalid;
   logic        r_m1_rvalid;
   logic        r_busy;

   // Next-state and Mealy grant decode; m1 wins only as sole requester or on its round-robin turn
   always_comb begin
      w_state_nxt = r_state;
      w_pick_m1   = 1'b0;
      w_m0_gnt    = 1'b0;
      w_m1_gnt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (arb.m0_req || arb.m1_req) begin
               if (arb.m1_req && (!arb.m0_req ||
                   ((ROUND_ROBIN == 1'b1) && (r_last_grant == 1'b0)))) begin
                  w_pick_m1 = 1'b1;
               end else begin
                  w_pick_m1 = 1'b0;
               end
               w_m0_gnt    = ~w_pick_m1;
               w_m1_gnt    = w_pick_m1;
               w_state_nxt = ST_ACCESS;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACCESS: w_state_nxt = ST_RESP;
         ST_RESP:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Command latch, bus drive, read capture and completion pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_winner     <= 1'b0;
         r_last_grant <= 1'b1;
         r_bus_we     <= 1'b0;
         r_bus_addr   <= 32'h0000_0000;
         r_bus_wdata  <= 32'h0000_0000;
         r_m0_rdata   <= 32'h0000_0000;
         r_m1_rdata   <= 32'h0000_0000;
         r_m0_rvalid  <= 1'b0;
         r_m1_rvalid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_m0_rvalid <= (r_state == ST_ACCESS) && (r_winner == 1'b0);
         r_m1_rvalid <= (r_state == ST_ACCESS) && (r_winner == 1'b1);
         if (w_m0_gnt || w_m1_gnt) begin
            r_winner     <= w_m1_gnt;
            r_last_grant <= w_m1_gnt;
            r_bus_we     <= w_m1_gnt ? arb.m1_we    : arb.m0_we;
            r_bus_addr   <= w_m1_gnt ? arb.m1_addr  : arb.m0_addr;
            r_bus_wdata  <= w_m1_gnt ? arb.m1_wdata : arb.m0_wdata;
         end else if (r_state == ST_ACCESS) begin
            // bus_we is only ever high for the single ACCESS cycle
            r_bus_we <= 1'b0;
            if (r_winner) begin
               r_m1_rdata <= arb.bus_rdata;
            end else begin
               r_m0_rdata <= arb.bus_rdata;
            end
         end else begin
            r_bus_we <= 1'b0;
         end
      end
   end

   assign arb.m0_gnt    = w_m0_gnt;
   assign arb.m1_gnt    = w_m1_gnt;
   assign arb.m0_rvalid = r_m0_rvalid;
   assign arb.m1_rvalid = r_m1_rvalid;
   assign arb.m0_rdata  = r_m0_rdata;
   assign arb.m1_rdata  = r_m1_rdata;
   assign arb.bus_we    = r_bus_we;
   assign arb.bus_addr  = r_bus_addr;
   assign arb.bus_wdata = r_bus_wdata;
   assign arb.busy      = r_busy;

   dmem_arbiter_chk u_chk (
      .clk       (clk),
      .reset     (reset),
      .m0_gnt    (w_m0_gnt),
      .m1_gnt    (w_m1_gnt),
      .m0_rvalid (r_m0_rvalid),
      .m1_rvalid (r_m1_rvalid),
      .bus_we    (r_bus_we),
      .busy      (r_busy)
   );
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the data-memory/IO bus (data memory below address bit 7, memory-mapped IO at address bit 7 = 1) between the CPU data port (m0) and a secondary master (m1), such as a debug loader or DMA engine. It accepts one request at a time and latches its command. It drives the shared bus for exactly one cycle, then returns registered read data with a one-cycle valid pulse. It sits between the masters and the memory/IO decoder; the decoder's read path is combinational from address.

## Interface
- ROUND_ROBIN, 1, 1 = alternate priority after each grant; 0 = m0 always has fixed priority.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- m0_req, m1_req  in  1  request, held high until the matching gnt is seen.
- m0_we, m1_we  in  1  1 = write, 0 = read; must be stable while req is high.
- m0_addr, m1_addr  in  32  byte address; stable while req is high.
- m0_wdata, m1_wdata  in  32  write data; stable while req is high.
- m0_gnt, m1_gnt  out  1  one-cycle pulse: the request was accepted and its command latched.
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse: the transaction completed (reads and writes); rdata is valid.
- m0_rdata, m1_rdata  out  32  registered read data, held until the next completion for that master.
- bus_we  out  1  write enable to the memory/IO decoder.
- bus_addr  out  32  address to the decoder.
- bus_wdata  out  32  write data to the decoder.
- bus_rdata  in  32  combinational read data from the decoder.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- State machine with three states.
  - IDLE: evaluate requests.
    - If any req is high, pick a winner, latch its we/addr/wdata, assert its gnt this cycle (Mealy, combinational from req and priority), record the winner's id, and go to ACCESS.
    - With no request, stay in IDLE.
  - ACCESS: drive bus_addr/bus_wdata from the latched values and set bus_we = latched we. At the rising edge ending ACCESS, capture bus_rdata into the winner's rdata register, then go to RESP.
  - RESP: assert the winner's rvalid for one cycle, then go to IDLE unconditionally.
- Priority
  - ROUND_ROBIN=1: a last_grant register; the master not granted last wins a tie. After reset last_grant = m1, so m0 wins the first tie.
  - ROUND_ROBIN=0: m0 wins every tie.
  - A sole requester always wins, regardless of last_grant.
- Writes also update the winner's rdata with bus_rdata, which reads the old or don't-care value; benches check rdata only for reads.
- Bus outputs outside ACCESS: bus_we = 0; bus_addr and bus_wdata hold the last latched values (0 after reset).
- A req still high after its gnt (master not yet deasserted) is evaluated as a new request at the next IDLE. Masters must drop req in the cycle after gnt to avoid a duplicate transaction.
- Reset values: state IDLE, all gnt/rvalid/bus_we/busy = 0, bus_addr = bus_wdata = 0, m0_rdata = m1_rdata = 0, last_grant = m1.

## Timing
- Request accepted in cycle N (gnt high in N): bus active in N+1, rvalid high in N+2, IDLE again in N+3.
- A new accept is possible in N+3; peak throughput is one transaction per 3 cycles.
- The write commits at the rising edge ending cycle N+1; the memory/IO sees exactly one bus_we cycle per write.
- Read data equals the bus_rdata sampled at the end of N+1 and is visible on rdata from N+2.
- gnt and rvalid are never high for both masters in the same cycle. At most one gnt pulse occurs per 3 cycles.
- Reset asserted mid-transaction (ACCESS or RESP):
  - The transaction is aborted immediately.
  - bus_we drops asynchronously, so no write occurs on the following edge.
  - No rvalid is issued.
  - The master must re-request after reset.
- Simultaneous req on both masters in IDLE: exactly one gnt, chosen by the priority rules. The loser waits and is granted at the next IDLE (N+3) if its req is still high.

## Test plan
- Single read: write 0x12345678 directly at address 0x10, then m0 reads 0x10. Expect m0_gnt in N, bus_addr = 0x10 with bus_we = 0 in N+1, m0_rvalid with m0_rdata = 0x12345678 in N+2, busy low in N+3.
- Single write: m1 writes 0xDEADBEEF to address 0x20. Expect bus_we high only in N+1; a follow-up m0 read of 0x20 returns 0xDEADBEEF; m1_rvalid pulses in N+2.
- Contention, ROUND_ROBIN=1: both masters hold req continuously after reset. Expect grant order m0, m1, m0, m1, with gnts 3 cycles apart and never overlapping.
- Contention, ROUND_ROBIN=0: both masters hold req. Expect m0 granted every time; m1 is granted only after m0 drops req.
- IO path: m0 writes 0x000000FF to address 0x80 (IO). Expect bus_addr[7] = 1 and bus_we = 1 for exactly one cycle; an m0 read of 0x80 returns the IO readback value.
- Reset in ACCESS: assert reset during a write to address 0x30 holding 0x0. Expect bus_we forced to 0 immediately, no rvalid, and a later read of 0x30 returns 0x0; after reset, the first tie goes to m0.
